alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Single-entry pipeline register between decode and the ALU in the MIPS-style execute stage.
- Selects and forwards ALU operands, validates the 4-bit ALU function code, and holds the issued op steady under back-pressure.
- Outputs drive the ALU's func/in1/in2 directly. The ALU result is fed back in for execute-to-execute forwarding.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.
- NREG_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  kill held op and any op offered this cycle
- in_valid  in  1  decode offers an op
- in_ready  out  1  stage accepts this cycle
- in_func  in  4  ALU function code; legal values are 0..8
- in_src1_sel  in  1  0: rs, 1: rt
- in_src2_sel  in  2  0: rt, 1: sign-extended imm, 2: zero-extended imm, 3: {27'b0, shamt}
- in_rs_idx, in_rt_idx  in  5  source register indices
- in_rs_val, in_rt_val  in  32  register-file read data
- in_imm  in  16  immediate
- in_shamt  in  5  shift amount
- in_dst  in  5  destination register
- in_wen  in  1  op writes in_dst
- ex_result  in  32  ALU output for the currently held op
- fwd_mem_valid  in  1  memory-stage forward valid
- fwd_mem_idx  in  5  memory-stage forward index
- fwd_mem_data  in  32  memory-stage forward data
- fwd_wb_valid  in  1  writeback-stage forward valid
- fwd_wb_idx  in  5  writeback-stage forward index
- fwd_wb_data  in  32  writeback-stage forward data
- out_valid  out  1  held op valid
- out_ready  in  1  downstream consumes the held op
- out_func  out  4  to ALU func
- out_in1, out_in2  out  32  to ALU in1/in2
- out_dst  out  5  destination register of held op
- out_wen  out  1  write enable of held op
- out_illegal  out  1  held op had func > 8
- stall_cnt  out  32  back-pressure cycle counter

Behaviour:
- Reset values: all outputs are 0, including out_valid, out_func, out_in1/out_in2, out_dst, out_wen, out_illegal and stall_cnt. Reset overrides flush and any handshake in the same cycle.
- in_ready = !flush && (!out_valid || out_ready). This path is combinational.
- accept = in_valid && in_ready. On accept, all out_* registers load next edge and out_valid becomes 1. Latency is 1 cycle.
- No accept and out_ready=1: out_valid becomes 0. No accept and out_ready=0: all out_* hold bit-stable.
- flush=1: out_valid becomes 0 next edge. The offered op is dropped. Data registers may keep stale values.
- Operand resolution happens at accept time. The captured value is final; there is no re-forwarding while stalled.
- Forwarding per source register (rs, rt), in priority order:
  1. Index 0 always reads 0.
  2. EX forward: ex_result, if out_valid && out_wen && out_dst == idx && out_ready. A held producer is always consumed when accept occurs, so out_ready is implied.
  3. MEM forward: fwd_mem_data, if fwd_mem_valid && fwd_mem_idx == idx.
  4. WB forward: fwd_wb_data, if fwd_wb_valid && fwd_wb_idx == idx.
  5. Otherwise, the register-file value.
- in1 = resolved rs or rt per in_src1_sel.
- in2 per in_src2_sel:
  - 0: resolved rt
  - 1: {{16{imm[15]}}, imm}
  - 2: {16'b0, imm}
  - 3: {27'b0, shamt}
- Illegal func: in_func > 8 captures out_func = 4'b0011 (add), out_illegal = 1 and out_wen = 0. Operands are captured normally.
- stall_cnt increments by 1 each cycle that out_valid && !out_ready && !flush. It wraps from 0xFFFFFFFF to 0 and is cleared only by reset.
- Simultaneous flush and out_ready: flush wins, so out_valid becomes 0. The ALU may still consume in that cycle.

Test Plan:
- Reset, then in_valid=1, func=3, src1=rs, rs_val=5, src2=1, imm=0xFFFF → next cycle out_valid=1, out_in1=5, out_in2=0xFFFFFFFF, out_func=3.
- Held op with dst=8, wen=1, ex_result=0x10, out_ready=1; new op rs_idx=8 with fwd_mem also matching idx 8 (data 0x99) → out_in1=0x10. EX forward beats MEM.
- out_ready=0 for 3 cycles with a new in_valid offered → in_ready=0, out_* stable, stall_cnt increments 0→3, op accepted the cycle out_ready returns to 1.
- in_func=9, in_wen=1 → out_func=3, out_illegal=1, out_wen=0. rs_idx=0 with rs_val=0x1234 → out_in1=0.
- flush=1 while out_valid=1 and in_valid=1 → in_ready=0, out_valid=0 next cycle, stall_cnt unchanged.
- src2_sel=3, shamt=31 → out_in2=0x1F. src2_sel=2, imm=0x8000 → out_in2=0x00008000. Also check reset mid-stall clears out_valid and stall_cnt.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: single-entry pipeline register between decode and the ALU.
// Resolves operands at accept time, using forwarding from EX, MEM and WB.
// Validates the ALU function code and holds the issued op steady under
// back-pressure. A free-running counter counts stalled cycles.
module alu_issue_stage #(
  parameter int WIDTH  = 32,
  parameter int NREG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  // decode side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_func,
  input  logic              in_src1_sel,
  input  logic [1:0]        in_src2_sel,
  input  logic [NREG_W-1:0] in_rs_idx,
  input  logic [NREG_W-1:0] in_rt_idx,
  input  logic [WIDTH-1:0]  in_rs_val,
  input  logic [WIDTH-1:0]  in_rt_val,
  input  logic [15:0]       in_imm,
  input  logic [4:0]        in_shamt,
  input  logic [NREG_W-1:0] in_dst,
  input  logic              in_wen,
  // forwarding sources
  input  logic [WIDTH-1:0]  ex_result,
  input  logic              fwd_mem_valid,
  input  logic [NREG_W-1:0] fwd_mem_idx,
  input  logic [WIDTH-1:0]  fwd_mem_data,
  input  logic              fwd_wb_valid,
  input  logic [NREG_W-1:0] fwd_wb_idx,
  input  logic [WIDTH-1:0]  fwd_wb_data,
  // ALU side
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_func,
  output logic [WIDTH-1:0]  out_in1,
  output logic [WIDTH-1:0]  out_in2,
  output logic [NREG_W-1:0] out_dst,
  output logic              out_wen,
  output logic              out_illegal,
  output logic [31:0]       stall_cnt
);

  localparam logic [3:0] FUNC_ADD = 4'b0011;
  localparam logic [3:0] FUNC_MAX = 4'd8;

  logic              out_valid_q,   out_valid_d;
  logic [3:0]        out_func_q,    out_func_d;
  logic [WIDTH-1:0]  out_in1_q,     out_in1_d;
  logic [WIDTH-1:0]  out_in2_q,     out_in2_d;
  logic [NREG_W-1:0] out_dst_q,     out_dst_d;
  logic              out_wen_q,     out_wen_d;
  logic              out_illegal_q, out_illegal_d;
  logic [31:0]       stall_cnt_q,   stall_cnt_d;

  logic              accept;
  logic              ex_fwd_ok;
  logic              func_illegal;
  logic [WIDTH-1:0]  rs_res;
  logic [WIDTH-1:0]  rt_res;

  // Resolve one source register through the forwarding priority chain.
  function automatic logic [WIDTH-1:0] resolve(
    input logic [NREG_W-1:0] idx,
    input logic [WIDTH-1:0]  rf_val,
    input logic              ex_ok,
    input logic [NREG_W-1:0] ex_dst,
    input logic [WIDTH-1:0]  ex_val,
    input logic              mem_v,
    input logic [NREG_W-1:0] mem_idx,
    input logic [WIDTH-1:0]  mem_val,
    input logic              wb_v,
    input logic [NREG_W-1:0] wb_idx,
    input logic [WIDTH-1:0]  wb_val
  );
    if (idx == '0)                        return '0;
    else if (ex_ok && ex_dst == idx)      return ex_val;
    else if (mem_v && mem_idx == idx)     return mem_val;
    else if (wb_v && wb_idx == idx)       return wb_val;
    else                                  return rf_val;
  endfunction

  // Handshake and operand resolution for the op offered this cycle.
  always_comb begin
    in_ready     = !flush && (!out_valid_q || out_ready);
    accept       = in_valid && in_ready;
    // The held op is consumed whenever accept fires, so its result is live.
    ex_fwd_ok    = out_valid_q && out_wen_q && out_ready;
    func_illegal = in_func > FUNC_MAX;
    rs_res = resolve(in_rs_idx, in_rs_val, ex_fwd_ok, out_dst_q, ex_result,
                     fwd_mem_valid, fwd_mem_idx, fwd_mem_data,
                     fwd_wb_valid, fwd_wb_idx, fwd_wb_data);
    rt_res = resolve(in_rt_idx, in_rt_val, ex_fwd_ok, out_dst_q, ex_result,
                     fwd_mem_valid, fwd_mem_idx, fwd_mem_data,
                     fwd_wb_valid, fwd_wb_idx, fwd_wb_data);
  end

  // Next-state for the held op and the stall counter.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path infers a latch.
    out_valid_d   = out_valid_q;
    out_func_d    = out_func_q;
    out_in1_d     = out_in1_q;
    out_in2_d     = out_in2_q;
    out_dst_d     = out_dst_q;
    out_wen_d     = out_wen_q;
    out_illegal_d = out_illegal_q;
    stall_cnt_d   = stall_cnt_q;

    if (out_valid_q && !out_ready && !flush) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end

    if (accept) begin
      out_valid_d   = 1'b1;
      out_func_d    = func_illegal ? FUNC_ADD : in_func;
      out_illegal_d = func_illegal;
      out_wen_d     = in_wen && !func_illegal;
      out_dst_d     = in_dst;
      out_in1_d     = in_src1_sel ? rt_res : rs_res;
      unique case (in_src2_sel)
        2'd0:    out_in2_d = rt_res;
        2'd1:    out_in2_d = {{(WIDTH-16){in_imm[15]}}, in_imm};
        2'd2:    out_in2_d = {{(WIDTH-16){1'b0}}, in_imm};
        default: out_in2_d = {{(WIDTH-5){1'b0}}, in_shamt};
      endcase
    end else if (flush || out_ready) begin
      // Flushed or consumed: drop valid, data registers keep stale values.
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset wins over everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      // NOTE: data registers are reset too, since every output must read 0 after reset.
      out_valid_q   <= 1'b0;
      out_func_q    <= '0;
      out_in1_q     <= '0;
      out_in2_q     <= '0;
      out_dst_q     <= '0;
      out_wen_q     <= 1'b0;
      out_illegal_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_func_q    <= out_func_d;
      out_in1_q     <= out_in1_d;
      out_in2_q     <= out_in2_d;
      out_dst_q     <= out_dst_d;
      out_wen_q     <= out_wen_d;
      out_illegal_q <= out_illegal_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_func    = out_func_q;
  assign out_in1     = out_in1_q;
  assign out_in2     = out_in2_q;
  assign out_dst     = out_dst_q;
  assign out_wen     = out_wen_q;
  assign out_illegal = out_illegal_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and randomized checks of alu_issue_stage
// against a behavioural model of the issue register.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        in_valid, in_ready;
  logic [3:0]  in_func;
  logic        in_src1_sel;
  logic [1:0]  in_src2_sel;
  logic [4:0]  in_rs_idx, in_rt_idx;
  logic [31:0] in_rs_val, in_rt_val;
  logic [15:0] in_imm;
  logic [4:0]  in_shamt, in_dst;
  logic        in_wen;
  logic [31:0] ex_result;
  logic        fwd_mem_valid, fwd_wb_valid;
  logic [4:0]  fwd_mem_idx, fwd_wb_idx;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        out_valid, out_ready;
  logic [3:0]  out_func;
  logic [31:0] out_in1, out_in2;
  logic [4:0]  out_dst;
  logic        out_wen, out_illegal;
  logic [31:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  // Model of the held op.
  bit          m_valid;
  bit          m_data_known;
  logic [3:0]  m_func;
  logic [31:0] m_in1, m_in2;
  logic [4:0]  m_dst;
  bit          m_wen, m_ill;
  logic [31:0] m_stall;

  alu_issue_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
    .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel),
    .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_imm(in_imm), .in_shamt(in_shamt), .in_dst(in_dst), .in_wen(in_wen),
    .ex_result(ex_result),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_idx(fwd_mem_idx), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_idx(fwd_wb_idx), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_func(out_func),
    .out_in1(out_in1), .out_in2(out_in2), .out_dst(out_dst), .out_wen(out_wen),
    .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value a source register reads: zero register, then the youngest producer.
  function automatic logic [31:0] model_src(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return 32'd0;
    if (m_valid && m_wen && m_dst == idx) return ex_result;
    if (fwd_mem_valid && fwd_mem_idx == idx) return fwd_mem_data;
    if (fwd_wb_valid && fwd_wb_idx == idx) return fwd_wb_data;
    return rf;
  endfunction

  function automatic logic [31:0] model_in2(input logic [31:0] rt);
    case (in_src2_sel)
      2'd0:    return rt;
      2'd1:    return 32'(signed'(in_imm));
      2'd2:    return 32'(in_imm);
      default: return 32'(in_shamt);
    endcase
  endfunction

  // One clock: check in_ready, advance the model, then compare registered outputs.
  task automatic tick();
    bit          rdy, take;
    logic [31:0] rs, rt;
    #1;
    rdy = !flush && (!m_valid || out_ready);
    check("in_ready", 32'(in_ready), 32'(rdy));
    take = in_valid && rdy;
    rs = model_src(in_rs_idx, in_rs_val);
    rt = model_src(in_rt_idx, in_rt_val);
    if (reset) begin
      m_valid = 0; m_data_known = 1; m_func = 0; m_in1 = 0; m_in2 = 0;
      m_dst = 0; m_wen = 0; m_ill = 0; m_stall = 0;
    end else begin
      if (m_valid && !out_ready && !flush) m_stall = m_stall + 1;
      if (take) begin
        m_valid = 1; m_data_known = 1;
        m_ill   = in_func > 4'd8;
        m_func  = m_ill ? 4'd3 : in_func;
        m_wen   = in_wen && !m_ill;
        m_dst   = in_dst;
        m_in1   = in_src1_sel ? rt : rs;
        m_in2   = model_in2(rt);
      end else if (flush || out_ready) begin
        m_valid = 0; m_data_known = 0;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("stall_cnt", stall_cnt, m_stall);
    if (m_valid || m_data_known) begin
      check("out_func", 32'(out_func), 32'(m_func));
      check("out_in1", out_in1, m_in1);
      check("out_in2", out_in2, m_in2);
      check("out_dst", 32'(out_dst), 32'(m_dst));
      check("out_wen", 32'(out_wen), 32'(m_wen));
      check("out_illegal", 32'(out_illegal), 32'(m_ill));
    end
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_func = 0; in_src1_sel = 0; in_src2_sel = 0;
    in_rs_idx = 0; in_rt_idx = 0; in_rs_val = 0; in_rt_val = 0; in_imm = 0;
    in_shamt = 0; in_dst = 0; in_wen = 0; ex_result = 0;
    fwd_mem_valid = 0; fwd_mem_idx = 0; fwd_mem_data = 0;
    fwd_wb_valid = 0; fwd_wb_idx = 0; fwd_wb_data = 0; out_ready = 1;
  endtask

  initial begin
    idle();
    reset = 1;
    m_valid = 0; m_data_known = 0; m_stall = 0;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_in1", out_in1, 32'd0);
    check("rst_stall", stall_cnt, 32'd0);
    reset = 0;

    // Sign-extended immediate, rs from register file.
    in_valid = 1; in_func = 4'd3; in_src1_sel = 0; in_rs_idx = 5'd1; in_rs_val = 32'd5;
    in_src2_sel = 2'd1; in_imm = 16'hFFFF; in_dst = 5'd8; in_wen = 1;
    tick();
    check("first_in1", out_in1, 32'd5);
    check("first_in2", out_in2, 32'hFFFFFFFF);
    check("first_func", 32'(out_func), 32'd3);

    // EX forward beats MEM forward for a held producer of r8.
    in_rs_idx = 5'd8; in_rs_val = 32'h55; ex_result = 32'h10;
    fwd_mem_valid = 1; fwd_mem_idx = 5'd8; fwd_mem_data = 32'h99;
    in_dst = 5'd2; in_wen = 1; in_src2_sel = 2'd0;
    tick();
    check("ex_over_mem", out_in1, 32'h10);
    fwd_mem_valid = 0;

    // Three cycles of back-pressure with a new op waiting.
    out_ready = 0; in_rs_idx = 5'd2; in_dst = 5'd4; in_func = 4'd6;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_hold_in1", out_in1, 32'h10);
      check("stall_count", stall_cnt, 32'(i));
    end
    out_ready = 1; ex_result = 32'h77;
    tick();
    check("post_stall_in1", out_in1, 32'h77);
    check("post_stall_func", 32'(out_func), 32'd6);

    // Illegal func and zero-register source.
    in_func = 4'd9; in_wen = 1; in_rs_idx = 5'd0; in_rs_val = 32'h1234;
    tick();
    check("illegal_func", 32'(out_func), 32'd3);
    check("illegal_flag", 32'(out_illegal), 32'd1);
    check("illegal_wen", 32'(out_wen), 32'd0);
    check("zero_reg", out_in1, 32'd0);

    // Flush while holding and offering, with the ALU stalled.
    flush = 1; out_ready = 0; in_func = 4'd1;
    tick();
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_stall", stall_cnt, 32'd3);
    flush = 0; out_ready = 1;

    // Shift amount and zero-extended immediate.
    in_src2_sel = 2'd3; in_shamt = 5'd31; tick();
    check("shamt", out_in2, 32'h1F);
    in_src2_sel = 2'd2; in_imm = 16'h8000; tick();
    check("zext_imm", out_in2, 32'h00008000);

    // Reset in the middle of a stall.
    out_ready = 0; tick(); tick();
    reset = 1; tick();
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_stall", stall_cnt, 32'd0);
    reset = 0; out_ready = 1;

    // Randomized traffic with dense register-index collisions.
    for (int n = 0; n < 400; n++) begin
      reset         = ($urandom_range(0, 59) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      out_ready     = ($urandom_range(0, 9) < 7);
      in_valid      = ($urandom_range(0, 9) < 8);
      in_func       = 4'($urandom_range(0, 11));
      in_src1_sel   = 1'($urandom);
      in_src2_sel   = 2'($urandom);
      in_rs_idx     = 5'($urandom_range(0, 3));
      in_rt_idx     = 5'($urandom_range(0, 3));
      in_rs_val     = $urandom;
      in_rt_val     = $urandom;
      in_imm        = 16'($urandom);
      in_shamt      = 5'($urandom);
      in_dst        = 5'($urandom_range(0, 3));
      in_wen        = 1'($urandom);
      ex_result     = $urandom;
      fwd_mem_valid = 1'($urandom);
      fwd_mem_idx   = 5'($urandom_range(0, 3));
      fwd_mem_data  = $urandom;
      fwd_wb_valid  = 1'($urandom);
      fwd_wb_idx    = 5'($urandom_range(0, 3));
      fwd_wb_data   = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
